// File: rtl/debounced_decoder_n.sv
// debounced_decoder_n
//   Drives active-low one-hot board LEDs from slide switches. The raw switch
//   vector is synchronised and debounced as a whole, then decoded through a
//   registered output stage. An auto-scan mode steps the lit LED round-robin.
//
// Ports:
//   clk        system clock, single domain
//   rst        synchronous, active-high reset
//   sw         raw asynchronous select vector (SEL_W bits)
//   scan_mode  raw asynchronous switch: 1 = auto-scan, 0 = manual
//   en         output enable: 0 forces all LEDs dark, nothing else is affected
//   leds       active-low one-hot (2^SEL_W bits), registered
//   idx        index currently displayed, registered
//   changed    one-cycle pulse when idx changes value
//   state_dbg  current FSM state (0 = MANUAL, 1 = SCAN)
//
// Handshake: none. All inputs are levels and all outputs are registered
// levels/pulses, so there is no combinational path from input to output.
module debounced_decoder_n #(
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int SCAN_DIV        = 6000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sw,
    input  logic                    scan_mode,
    input  logic                    en,
    output logic [(1<<SEL_W)-1:0]   leds,
    output logic [SEL_W-1:0]        idx,
    output logic                    changed,
    output logic                    state_dbg
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    logic [SEL_W-1:0] r_sw_s1;
    logic [SEL_W-1:0] r_sw_s2;
    logic             r_scan_s1;
    logic             r_scan_s2;
    logic [SEL_W-1:0] r_cand;
    logic [SEL_W-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    state_t           r_state;
    logic [SEL_W-1:0] r_idx;
    logic [OUT_W-1:0] r_leds;
    logic             r_changed;

    logic [SEL_W-1:0] w_idx_next;

    // Next displayed index. Leaving scan mode takes priority over a scan
    // step that falls in the same cycle.
    always_comb begin
        w_idx_next = r_idx;
        case (r_state)
            ST_MANUAL: w_idx_next = r_stable;
            ST_SCAN: begin
                if (!r_scan_s2)
                    w_idx_next = r_stable;
                else if (r_div == DIV_MAX)
                    w_idx_next = r_idx + SEL_W'(1);
                else
                    w_idx_next = r_idx;
            end
            default: w_idx_next = r_stable;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_scan_s1 <= 1'b0;
            r_scan_s2 <= 1'b0;
            r_cand    <= '0;
            r_stable  <= '0;
            r_cnt     <= '0;
            r_div     <= '0;
            r_state   <= ST_MANUAL;
            r_idx     <= '0;
            r_leds    <= '1;
            r_changed <= 1'b0;
        end else begin
            r_sw_s1   <= sw;
            r_sw_s2   <= r_sw_s1;
            r_scan_s1 <= scan_mode;
            r_scan_s2 <= r_scan_s1;

            // Whole-vector debounce: any bit change restarts the count; the
            // count saturates once the candidate has been accepted.
            if (r_sw_s2 != r_cand) begin
                r_cand <= r_sw_s2;
                r_cnt  <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_cand;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_MANUAL: begin
                    if (r_scan_s2) begin
                        r_state <= ST_SCAN;
                        r_div   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!r_scan_s2) begin
                        r_state <= ST_MANUAL;
                        r_div   <= '0;
                    end else if (r_div == DIV_MAX) begin
                        r_div <= '0;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_MANUAL;
                    r_div   <= '0;
                end
            endcase

            r_idx     <= w_idx_next;
            r_leds    <= en ? ~(OUT_W'(1) << w_idx_next) : '1;
            r_changed <= (w_idx_next != r_idx);
        end
    end

    assign leds      = r_leds;
    assign idx       = r_idx;
    assign changed   = r_changed;
    assign state_dbg = r_state;

endmodule

// File: doc/debounced_decoder_n.md
Name: debounced_decoder_n

Overview:
Parametrised SEL_W-to-2^SEL_W one-hot decoder driving active-low board LEDs from slide switches. It is the next generation of the board's switch-to-LED decoder. It adds input synchronisation, vector debounce, a registered output, an enable, and an auto-scan mode that steps the lit LED round-robin. It sits directly between top-level switch pins and LED pins.

Parameters:
SEL_W, 2, select width; output width OUT_W = 2^SEL_W (localparam)
DEBOUNCE_CYCLES, 12000, consecutive stable cycles required before a new switch vector is accepted (≥1)
SCAN_DIV, 6000000, clock cycles per scan step in scan mode (≥1)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
sw  input  SEL_W  raw asynchronous switch vector (select)
scan_mode  input  1  raw asynchronous switch; 1 = auto-scan, 0 = manual
en  input  1  synchronous output enable; 0 = all LEDs dark
leds  output  OUT_W  active-low one-hot; selected bit 0, all others 1
idx  output  SEL_W  index currently displayed (registered)
changed  output  1  one-cycle pulse when idx changes value

Behaviour:
- One clock; reset is synchronous and active-high. All registers update on rising clk only.
- Reset values: leds all ones, idx 0, changed 0, sync flops 0, candidate 0, stable 0, debounce count 0, scan divider 0, state MANUAL.
- Synchroniser: sw and scan_mode each pass through a 2-flop synchroniser (s1, s2). scan_mode is not debounced.
- Debounce, whole vector:
  - If s2 != cand: cand <= s2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand; cnt holds (saturates).
  - Else: cnt <= cnt+1.
  - Any bit change restarts the count. A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- Latency: take edge e1 as the first edge sampling the new sw value. s2 is valid at e2, cand at e3, stable at e3+DEBOUNCE_CYCLES. idx and leds update at e4+DEBOUNCE_CYCLES.
- State machine, 2 states:
  - MANUAL: idx_next = stable. MANUAL -> SCAN when synced scan_mode = 1. On entry, the scan divider clears and scan index loads current idx.
  - SCAN: divider counts 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1, it wraps to 0 and idx_next = idx+1, modulo OUT_W (OUT_W-1 wraps to 0). SCAN -> MANUAL when synced scan_mode = 0. idx_next = stable in that same cycle, and the divider clears.
  - Debounce keeps tracking sw while in SCAN.
- Output register: idx <= idx_next. leds <= en ? ~(1 << idx_next) : all ones. changed <= (idx_next != idx).
- en affects leds only. idx, changed, state and counters keep running while en = 0. Re-asserting en shows the current idx on the next edge.
- Simultaneous events:
  - A debounce completion during SCAN updates stable but not idx.
  - A mode switch in the same cycle as a scan step: the mode switch wins, and idx takes stable.
- Reset mid-operation: all state returns to reset values on the edge rst is sampled high. Debounce restarts from zero, so a held switch takes the full latency to reappear.
- No combinational path from any input to any output.

Test Plan:
1. SEL_W=2, DEBOUNCE_CYCLES=4, rst 2 cycles, en=1, sw=00 -> after reset, leds=1110 and idx=0. leds=1111 only in the reset cycle.
2. sw 00->10 at e1, held -> leds=1011, idx=2, changed=1 for exactly one cycle at e8; no change at e1..e7.
3. sw=11 pulse for 3 cycles, then back to 00 -> leds stays 1110, changed never asserts.
4. scan_mode=1 with SCAN_DIV=3 from idx=1 -> idx steps 2,3,0,1 every 3 cycles, one changed pulse per step. scan_mode=0 with debounced sw=10 -> idx=2 within 3 cycles of scan_mode falling.
5. en=0 during scan -> leds=1111 while idx keeps advancing. en=1 at idx=3 -> leds=0111 next edge.
6. SEL_W=3, DEBOUNCE_CYCLES=2: sw=101 -> leds=11011111. Reset asserted mid-debounce of sw=011 -> leds=11111110 after reset, then 11110111 after the full latency.
